// File: rtl/es8388_cfg_ctrl_if.sv
// Control and I2C bus bundle between the ES8388 config sequencer
// and its surroundings (register table ROM, codec pins, top-level status).
interface es8388_cfg_ctrl_if;
    logic        start;
    logic [7:0]  cfg_idx;
    logic [15:0] cfg_word;
    logic        busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        scl;
    logic        sda_oe;
    logic        sda_i;

    modport master (
        output start, cfg_word, sda_i,
        input  cfg_idx, busy, cfg_done, cfg_err, scl, sda_oe
    );

    modport slave (
        input  start, cfg_word, sda_i,
        output cfg_idx, busy, cfg_done, cfg_err, scl, sda_oe
    );
endinterface

// File: rtl/es8388_cfg_ctrl.sv
// ES8388 power-up configuration sequencer: walks the register table
// and issues one I2C write per entry, with per-entry NACK retry.
module es8388_cfg_ctrl #(
    parameter logic [6:0] DEV_ADDR  = 7'h10,
    parameter int         CLK_DIV   = 125,
    parameter logic [7:0] REG_NUM   = 8'd40,
    parameter logic [1:0] MAX_RETRY = 2'd3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    es8388_cfg_ctrl_if.slave bus
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_STOP, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t        r_state, w_state;
    logic [1:0]    r_ph, w_ph;
    logic [1:0]    r_byte, w_byte;
    logic [3:0]    r_bit, w_bit;
    logic [15:0]   r_word, w_word;
    logic [7:0]    r_idx, w_idx;
    logic [1:0]    r_retry, w_retry;
    logic          r_nack, w_nack;
    logic [DW-1:0] r_div;

    logic          w_busy;
    logic          w_tick;
    logic          w_start_ok;
    logic [7:0]    w_cur_byte;
    logic          w_data_bit;
    logic          w_scl;
    logic          w_oe;

    assign w_busy = (r_state == S_START) || (r_state == S_BIT) ||
                    (r_state == S_STOP)  || (r_state == S_GAP);
    assign w_tick = w_busy && (r_div == DW'(CLK_DIV - 1));
    assign w_start_ok = bus.start && !w_busy;

    assign w_cur_byte = (r_byte == 2'd0) ? {DEV_ADDR, 1'b0} :
                        (r_byte == 2'd1) ? r_word[15:8] : r_word[7:0];
    assign w_data_bit = w_cur_byte[3'd7 - r_bit[2:0]];

    // Quarter-bit divider: runs only during a transfer, idle otherwise
    always_ff @(posedge i_clk) begin
        if (i_rst || !w_busy)
            r_div <= '0;
        else if (w_tick)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    // State and sequencing registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ph    <= 2'd0;
            r_byte  <= 2'd0;
            r_bit   <= 4'd0;
            r_word  <= 16'd0;
            r_idx   <= 8'd0;
            r_retry <= 2'd0;
            r_nack  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ph    <= w_ph;
            r_byte  <= w_byte;
            r_bit   <= w_bit;
            r_word  <= w_word;
            r_idx   <= w_idx;
            r_retry <= w_retry;
            r_nack  <= w_nack;
        end
    end

    // Next-state: phase advance on tick, byte/bit walk, retry decision
    always_comb begin
        w_state = r_state;
        w_ph    = r_ph;
        w_byte  = r_byte;
        w_bit   = r_bit;
        w_word  = r_word;
        w_idx   = r_idx;
        w_retry = r_retry;
        w_nack  = r_nack;
        if (w_start_ok) begin
            w_state = S_START;
            w_ph    = 2'd0;
            w_byte  = 2'd0;
            w_bit   = 4'd0;
            w_idx   = 8'd0;
            w_retry = 2'd0;
            w_nack  = 1'b0;
        end else if (w_tick) begin
            w_ph = r_ph + 2'd1;
            unique case (r_state)
                S_START: begin
                    if (r_ph == 2'd0)
                        w_word = bus.cfg_word;
                    if (r_ph == 2'd3) begin
                        w_state = S_BIT;
                        w_byte  = 2'd0;
                        w_bit   = 4'd0;
                    end
                end
                S_BIT: begin
                    if (r_ph == 2'd2 && r_bit == 4'd8)
                        w_nack = bus.sda_i;
                    if (r_ph == 2'd3) begin
                        if (r_bit != 4'd8)
                            w_bit = r_bit + 4'd1;
                        else if (r_nack || r_byte == 2'd2)
                            w_state = S_STOP;
                        else begin
                            w_byte = r_byte + 2'd1;
                            w_bit  = 4'd0;
                        end
                    end
                end
                S_STOP: begin
                    if (r_ph == 2'd3)
                        w_state = S_GAP;
                end
                S_GAP: begin
                    if (r_ph == 2'd3) begin
                        if (!r_nack) begin
                            if (r_idx == REG_NUM - 8'd1)
                                w_state = S_DONE;
                            else begin
                                w_idx   = r_idx + 8'd1;
                                w_retry = 2'd0;
                                w_state = S_START;
                            end
                        end else if (r_retry < MAX_RETRY) begin
                            w_retry = r_retry + 2'd1;
                            w_nack  = 1'b0;
                            w_state = S_START;
                        end else begin
                            w_state = S_ERR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decoded from state and quarter-bit phase
    always_comb begin
        w_scl = 1'b1;
        w_oe  = 1'b0;
        unique case (r_state)
            S_START: begin
                w_scl = (r_ph < 2'd2);
                w_oe  = 1'b1;
            end
            S_BIT: begin
                w_scl = (r_ph == 2'd1) || (r_ph == 2'd2);
                w_oe  = (r_bit == 4'd8) ? 1'b0 : ~w_data_bit;
            end
            S_STOP: begin
                w_scl = (r_ph != 2'd0);
                w_oe  = (r_ph < 2'd2);
            end
            default: ;
        endcase
    end

    assign bus.scl      = w_scl;
    assign bus.sda_oe   = w_oe;
    assign bus.busy     = w_busy;
    assign bus.cfg_done = (r_state == S_DONE);
    assign bus.cfg_err  = (r_state == S_ERR);
    assign bus.cfg_idx  = r_idx;
endmodule

// File: tb/tb_es8388_cfg_ctrl.sv
// Bench for es8388_cfg_ctrl: I2C slave model decodes bus writes and
// compares each finished transaction against a queue of expected ones.
module tb_es8388_cfg_ctrl;
    localparam int CLK_DIV = 4;
    localparam int TXN     = 120 * CLK_DIV;
    localparam int ABORT1  = 84 * CLK_DIV;
    localparam int ABORT0  = 48 * CLK_DIV;
    localparam int BUDGET  = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pull;

    always #5 clk = ~clk;

    es8388_cfg_ctrl_if bus();

    es8388_cfg_ctrl #(
        .DEV_ADDR (7'h10),
        .CLK_DIV  (CLK_DIV),
        .REG_NUM  (8'd3),
        .MAX_RETRY(2'd3)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    logic [15:0] tbl [4];
    initial begin
        tbl[0] = 16'h0180;
        tbl[1] = 16'h1234;
        tbl[2] = 16'hA55A;
        tbl[3] = 16'hFFFF;
    end

    assign bus.cfg_word = tbl[bus.cfg_idx[1:0]];
    assign bus.sda_i    = ~(bus.sda_oe | pull);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] pack(input logic [7:0] i, input int nb,
                                         input logic [7:0] b0,
                                         input logic [7:0] b1,
                                         input logic [7:0] b2);
        return {28'd0, i, 4'(nb), b0, b1, b2};
    endfunction

    logic [63:0] exp_q [$];
    int mode;
    bit idx1_nacked;
    int n_start;
    int n_stop;

    // I2C slave model, evaluated on the falling clk edge
    initial begin : slave
        bit pscl, psda, in_tx, ackslot, scl_v, sda_v, ack;
        int bitc, nb, last_rise, tcyc;
        logic [7:0] sh, tx_idx;
        logic [7:0] by [3];
        logic [63:0] obs;
        pull = 1'b0;
        pscl = 1'b1;
        psda = 1'b1;
        in_tx = 1'b0;
        ackslot = 1'b0;
        bitc = 0;
        nb = 0;
        last_rise = -1;
        tcyc = 0;
        sh = 8'd0;
        tx_idx = 8'd0;
        for (int k = 0; k < 3; k++) by[k] = 8'd0;
        forever begin
            @(negedge clk);
            tcyc++;
            scl_v = bus.scl;
            sda_v = bus.sda_i;
            if (rst) begin
                in_tx = 1'b0;
                pull = 1'b0;
                ackslot = 1'b0;
            end else if (pscl && scl_v && psda && !sda_v) begin
                n_start++;
                in_tx = 1'b1;
                bitc = 0;
                nb = 0;
                ackslot = 1'b0;
                last_rise = -1;
                tx_idx = bus.cfg_idx;
                for (int k = 0; k < 3; k++) by[k] = 8'd0;
            end else if (in_tx && pscl && scl_v && !psda && sda_v) begin
                n_stop++;
                in_tx = 1'b0;
                obs = pack(tx_idx, nb, by[0], by[1], by[2]);
                if (exp_q.size() == 0)
                    chk("sb_extra", obs, '1);
                else
                    chk("txn", obs, exp_q.pop_front());
            end else if (in_tx && scl_v && !pscl) begin
                if (last_rise >= 0)
                    chk("scl_per", 64'(tcyc - last_rise), 64'(4 * CLK_DIV));
                last_rise = tcyc;
                if (!ackslot && bitc < 8) begin
                    sh = {sh[6:0], sda_v};
                    bitc++;
                end
            end else if (in_tx && !scl_v && pscl) begin
                if (ackslot) begin
                    pull = 1'b0;
                    ackslot = 1'b0;
                    bitc = 0;
                end else if (bitc == 8) begin
                    if (nb < 3) by[nb] = sh;
                    ack = 1'b1;
                    if (mode == 1 && nb == 1 && tx_idx == 8'd1 &&
                        !idx1_nacked) begin
                        idx1_nacked = 1'b1;
                        ack = 1'b0;
                    end
                    if (mode == 2 && nb == 0)
                        ack = 1'b0;
                    nb++;
                    ackslot = 1'b1;
                    pull = ack;
                end
            end
            pscl = scl_v;
            psda = sda_v;
        end
    end

    task automatic push_full();
        for (int i = 0; i < 3; i++)
            exp_q.push_back(pack(8'(i), 3, 8'h20, tbl[i][15:8], tbl[i][7:0]));
    endtask

    task automatic run_seq(input int p1, input int p2, output int lat);
        int cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        chk("go_busy", 64'(bus.busy), 64'd1);
        chk("go_done", 64'(bus.cfg_done), 64'd0);
        chk("go_err", 64'(bus.cfg_err), 64'd0);
        chk("go_idx", 64'(bus.cfg_idx), 64'd0);
        while (bus.busy && cyc < BUDGET) begin
            bus.start = (cyc == p1) || (cyc == p2);
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            if (p1 > 0 && cyc == p1 + 2) begin
                chk("ign_idx", 64'(bus.cfg_idx), 64'd0);
                chk("ign_busy", 64'(bus.busy), 64'd1);
            end
        end
        chk("seq_end", 64'(bus.busy), 64'd0);
        lat = cyc - 1;
    endtask

    task automatic chk_flags(input string tag, input bit done, input bit err,
                             input logic [7:0] idx);
        chk({tag, "_done"}, 64'(bus.cfg_done), 64'(done));
        chk({tag, "_err"}, 64'(bus.cfg_err), 64'(err));
        chk({tag, "_idx"}, 64'(bus.cfg_idx), 64'(idx));
        chk({tag, "_sb"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_scl"}, 64'(bus.scl), 64'd1);
        chk({tag, "_oe"}, 64'(bus.sda_oe), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.cfg_done), 64'd0);
        chk({tag, "_err"}, 64'(bus.cfg_err), 64'd0);
        chk({tag, "_idx"}, 64'(bus.cfg_idx), 64'd0);
    endtask

    initial begin : main
        int lat;
        bus.start = 1'b0;
        mode = 0;
        idx1_nacked = 1'b0;
        n_start = 0;
        n_stop = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("rst");
        rst = 1'b0;
        @(negedge clk);

        mode = 0;
        n_start = 0;
        n_stop = 0;
        push_full();
        run_seq(0, 0, lat);
        chk("t1_lat", 64'(lat), 64'(3 * TXN));
        chk_flags("t1", 1'b1, 1'b0, 8'd2);
        chk("t1_starts", 64'(n_start), 64'd3);
        chk("t1_stops", 64'(n_stop), 64'd3);

        mode = 1;
        idx1_nacked = 1'b0;
        exp_q.push_back(pack(8'd0, 3, 8'h20, 8'h01, 8'h80));
        exp_q.push_back(pack(8'd1, 2, 8'h20, 8'h12, 8'h00));
        exp_q.push_back(pack(8'd1, 3, 8'h20, 8'h12, 8'h34));
        exp_q.push_back(pack(8'd2, 3, 8'h20, 8'hA5, 8'h5A));
        run_seq(0, 0, lat);
        chk("t3_lat", 64'(lat), 64'(3 * TXN + ABORT1));
        chk_flags("t3", 1'b1, 1'b0, 8'd2);

        mode = 2;
        n_start = 0;
        n_stop = 0;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(pack(8'd0, 1, 8'h20, 8'h00, 8'h00));
        run_seq(0, 0, lat);
        chk("t4_lat", 64'(lat), 64'(4 * ABORT0));
        chk_flags("t4", 1'b0, 1'b1, 8'd0);
        chk("t4_starts", 64'(n_start), 64'd4);
        chk("t4_stops", 64'(n_stop), 64'd4);

        mode = 0;
        push_full();
        run_seq(50, 700, lat);
        chk("t5_lat", 64'(lat), 64'(3 * TXN));
        chk_flags("t5", 1'b1, 1'b0, 8'd2);
        push_full();
        run_seq(0, 0, lat);
        chk("t5b_lat", 64'(lat), 64'(3 * TXN));
        chk_flags("t5b", 1'b1, 1'b0, 8'd2);

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (100) @(negedge clk);
        chk("t6_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("t6");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_full();
        run_seq(0, 0, lat);
        chk("t6_lat", 64'(lat), 64'(3 * TXN));
        chk_flags("t6b", 1'b1, 1'b0, 8'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
